inv_key_sched: RTL and testbench
================================

# inv_key_sched

Sequential AES-128 key-expansion block for the decryption datapath. It accepts a 128-bit cipher key and expands it into the 11 round keys RK0..RK10, one per cycle, into an internal register file. Once expansion finishes, it serves any round key by index through a registered read port. The decryption controller reads keys in reverse order, RK10 first, then RK9..RK0, and drives them into the `key_i` input of the inverse round stage.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_i`  in  128  cipher key. `key_i[127:120]` is key byte 0; `w0 = key_i[127:96]`.
- `key_load`  in  1  one-cycle request to capture `key_i` and start expansion.
- `rk_idx_i`  in  4  round-key index to read, 0..10.
- `rk_o`  out  128  registered round key `RK[rk_idx_i]`.
- `busy`  out  1  high while expansion is in progress.
- `key_ready`  out  1  high when RK0..RK10 are valid.

## Operation
- Storage: 11 x 128-bit round-key registers plus a 4-bit round counter `rc_cnt`, an 8-bit `rcon` register and a 2-bit FSM.
- States and transitions:
  - IDLE -> EXPAND on `key_load`.
  - EXPAND -> READY when `rc_cnt` == 10 has been written.
  - READY -> EXPAND on `key_load`.
- IDLE with `key_load`:
  - RK0 <= `key_i`.
  - `rc_cnt` <= 1, `rcon` <= 8'h01.
  - Go to EXPAND.
- EXPAND, each cycle, with `prev = RK[rc_cnt-1]` split into words p0..p3:
  - `t = SubWord(RotWord(p3)) ^ {rcon, 24'h0}`.
  - `RotWord(w) = {w[23:0], w[31:24]}`.
  - SubWord applies the forward AES S-box to each of the 4 bytes. Reuse the team's forward S-box module; the design needs exactly 4 S-box instances.
  - `n0 = p0^t`, `n1 = p1^n0`, `n2 = p2^n1`, `n3 = p3^n2`.
  - `RK[rc_cnt] <= {n0,n1,n2,n3}`.
  - `rc_cnt` increments.
  - `rcon <= xtime(rcon)`, i.e. `{rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00)`. This yields the sequence 01,02,04,08,10,20,40,80,1B,36.
- `key_load` while in EXPAND is ignored. The expansion in flight completes unchanged.
- READY with `key_load`:
  - Recapture RK0 from `key_i` and restart expansion exactly as from IDLE.
  - `key_ready` drops on the next edge.
  - RK1..RK10 keep their old contents until overwritten, but are not readable as valid.
- Read port:
  - Every cycle, `rk_o <= (key_ready && rk_idx_i <= 10) ? RK[rk_idx_i] : 128'h0`.
  - `key_ready` here is the registered value current in that cycle.
  - Index 11..15 always returns zero.
- Reset (`rst_n` low, asynchronous, any state including mid-EXPAND):
  - FSM returns to IDLE; `rc_cnt` = 0; `rcon` = 8'h01.
  - `busy` = 0, `key_ready` = 0, `rk_o` = 0.
  - The round-key registers need not be cleared.
  - After release, a fresh `key_load` is required.

## Timing
- `key_load` sampled high at edge E0 (IDLE or READY).
  - `busy` = 1 from E0 through E10.
  - RK1 is written at E1, ..., RK10 at E10.
  - At E10: `busy` <= 0 and `key_ready` <= 1.
- First valid read:
  - `rk_idx_i` presented in the cycle after E10 returns data on `rk_o` after E11.
  - Read latency is 1 cycle.
- Expansion throughput: one new key accepted every 11 cycles at most.
- `busy` and `key_ready` are never both 1. Both are registered outputs.
- `rk_idx_i` may change every cycle. `rk_o` follows one cycle later with no bubbles.

## Test plan
- FIPS-197 key expansion:
  - Stimulus: reset, then `key_load` with `key_i` = 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: `busy` high for exactly 10 cycles; `key_ready` rises 10 cycles after `key_load`.
  - Read index 0 -> 2b7e151628aed2a6abf7158809cf4f3c.
  - Read index 1 -> a0fafe1788542cb123a339392a6c7605.
  - Read index 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reverse sweep and rekey:
  - Stimulus: sweep `rk_idx_i` 10 down to 0 on consecutive cycles.
  - Required: `rk_o` shows RK10..RK0 with 1-cycle lag and no gaps.
  - Stimulus: in READY, `key_load` with key 000102030405060708090a0b0c0d0e0f.
  - Required: `key_ready` = 0 on the next cycle; after completion, index 10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- Load during expansion:
  - Stimulus: second `key_load` with a different key 4 cycles into EXPAND.
  - Required: ignored; RK10 matches the first key; completion time unchanged.
- Out-of-range and not-ready reads:
  - Stimulus: `rk_idx_i` = 11 and 15 while READY.
  - Required: `rk_o` = 0.
  - Stimulus: any index while `busy`.
  - Required: `rk_o` = 0.
- Asynchronous reset mid-expansion:
  - Stimulus: assert `rst_n` low asynchronously at `rc_cnt` = 6, between clock edges.
  - Required: `busy`, `key_ready` and `rk_o` go 0 immediately, without waiting for a clock edge.
  - Stimulus: release reset, then reload the FIPS-197 key.
  - Required: correct RK10, showing `rcon` restarted at 01.

Source files
------------

// File: rtl/inv_key_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes_sbox_fwd / inv_key_sched
//  Description : Forward AES S-box, and an AES-128 key-expansion block that
//                builds RK0..RK10 one per cycle and serves them through a
//                registered read port for the decryption datapath.
//  Revision    : 1.0  initial release
// ============================================================================

// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox_fwd (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60;
  logic [7:0] w_x120, w_x240, w_x252, w_inv;

  // Inverse as x^254 via an addition chain; 0 maps to 0 naturally
  always_comb begin
    w_x2   = gf_mul(byte_i, byte_i);
    w_x3   = gf_mul(w_x2, byte_i);
    w_x6   = gf_mul(w_x3, w_x3);
    w_x12  = gf_mul(w_x6, w_x6);
    w_x15  = gf_mul(w_x12, w_x3);
    w_x30  = gf_mul(w_x15, w_x15);
    w_x60  = gf_mul(w_x30, w_x30);
    w_x120 = gf_mul(w_x60, w_x60);
    w_x240 = gf_mul(w_x120, w_x120);
    w_x252 = gf_mul(w_x240, w_x12);
    w_inv  = gf_mul(w_x252, w_x2);
  end

  // Affine transform: inv ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  always_comb begin
    byte_o = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule

module inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_i,
  input  logic         key_load,
  input  logic [3:0]   rk_idx_i,
  output logic [127:0] rk_o,
  output logic         busy,
  output logic         key_ready
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_EXPAND = 2'd1;
  localparam logic [1:0] C_READY  = 2'd2;
  localparam logic [3:0] C_LAST   = 4'd10;

  logic [1:0]   state_q, state_d;
  logic [3:0]   rc_cnt_q, rc_cnt_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         key_ready_q, key_ready_d;
  logic [127:0] rk_o_q, rk_o_d;
  logic [127:0] rk_q [0:10];

  logic         w_load;
  logic         w_expand;
  logic [3:0]   w_prev_idx;
  logic [127:0] w_prev;
  logic [127:0] w_rd;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t, w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_next;

  // A load is honoured only outside EXPAND; a load mid-expansion is dropped
  assign w_load     = key_load && ((state_q == C_IDLE) || (state_q == C_READY));
  assign w_expand   = (state_q == C_EXPAND);
  assign w_prev_idx = rc_cnt_q - 4'd1;

  // Previous round key and read-port data selected by explicit index match
  always_comb begin
    w_prev = '0;
    w_rd   = '0;
    for (int i = 0; i < 11; i++) begin
      if (w_prev_idx == 4'(i)) w_prev = rk_q[i];
      if (rk_idx_i == 4'(i))   w_rd   = rk_q[i];
    end
  end

  assign w_rot = {w_prev[23:0], w_prev[31:24]};

  generate
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox_fwd u_sbox (
        .byte_i (w_rot[8*b +: 8]),
        .byte_o (w_sub[8*b +: 8])
      );
    end
  endgenerate

  // Next round key from the previous one (word p0 is the most significant)
  always_comb begin
    w_t    = w_sub ^ {rcon_q, 24'h000000};
    w_n0   = w_prev[127:96] ^ w_t;
    w_n1   = w_prev[95:64]  ^ w_n0;
    w_n2   = w_prev[63:32]  ^ w_n1;
    w_n3   = w_prev[31:0]   ^ w_n2;
    w_next = {w_n0, w_n1, w_n2, w_n3};
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:   if (key_load) state_d = C_EXPAND;
      C_EXPAND: if (rc_cnt_q == C_LAST) state_d = C_READY;
      C_READY:  if (key_load) state_d = C_EXPAND;
      default:  state_d = C_IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so they can be registered
  always_comb begin
    busy_d      = (state_d == C_EXPAND);
    key_ready_d = (state_d == C_READY);
  end

  // Round counter and rcon progression (rcon advances by xtime each round)
  always_comb begin
    rc_cnt_d = rc_cnt_q;
    rcon_d   = rcon_q;
    if (w_load) begin
      rc_cnt_d = 4'd1;
      rcon_d   = 8'h01;
    end else if (w_expand) begin
      rc_cnt_d = rc_cnt_q + 4'd1;
      rcon_d   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
    end
  end

  // Read port: zero unless keys are valid and the index is in range
  always_comb begin
    rk_o_d = (key_ready_q && (rk_idx_i <= C_LAST)) ? w_rd : '0;
  end

  // Control and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= C_IDLE;
      rc_cnt_q    <= 4'd0;
      rcon_q      <= 8'h01;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      rk_o_q      <= '0;
    end else begin
      state_q     <= state_d;
      rc_cnt_q    <= rc_cnt_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      rk_o_q      <= rk_o_d;
    end
  end

  // Round-key storage; contents are only trusted while key_ready is high
  always_ff @(posedge clk) begin
    if (w_load) rk_q[0] <= key_i;
    if (w_expand) begin
      for (int i = 1; i < 11; i++) begin
        if (rc_cnt_q == 4'(i)) rk_q[i] <= w_next;
      end
    end
  end

  assign rk_o      = rk_o_q;
  assign busy      = busy_q;
  assign key_ready = key_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_key_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_inv_key_sched
//  Description : Scoreboard bench for inv_key_sched against a word-level
//                FIPS-197 key-expansion model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inv_key_sched;

  localparam logic [127:0] C_FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] C_FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C_SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_i;
  logic         key_load;
  logic [3:0]   rk_idx_i;
  logic [127:0] rk_o;
  logic         busy;
  logic         key_ready;

  logic         rd_issue;
  logic [127:0] exp_q [$];
  logic [7:0]   sb [0:255];
  logic [127:0] mdl [0:10];
  int           n_checks;
  int           n_errors;

  inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_i     (key_i),
    .key_load  (key_load),
    .rk_idx_i  (rk_idx_i),
    .rk_o      (rk_o),
    .busy      (busy),
    .key_ready (key_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Plain shift-and-add GF(2^8) product
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) p = p ^ a;
      a = a << 1;
      if (a & 'h100) a = a ^ 'h11b;
    end
    return p;
  endfunction

  // S-box table: inverse by exhaustive search, then bitwise affine map
  task automatic build_sbox();
    int inv, s, bit_v;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
      s = 0;
      for (int i = 0; i < 8; i++) begin
        bit_v = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
        s = s | (bit_v << i);
      end
      sb[x] = 8'(s);
    end
  endtask

  // FIPS-197 word-array key expansion
  task automatic expand_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    int rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 1;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ (32'(rc) << 24);
        rc = rc << 1;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Monitor: one rk_o comparison per read issued in the previous cycle
  initial begin : monitor
    logic cap;
    logic [127:0] e;
    forever begin
      @(posedge clk);
      cap = rd_issue;
      #1;
      if (cap) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rk_o", rk_o, e);
        end
      end
    end
  end

  // busy and key_ready must never be high together
  always @(negedge clk) begin
    if (rst_n) chk("busy_and_ready", {127'd0, busy & key_ready}, 128'd0);
  end

  task automatic load_key(input logic [127:0] k);
    key_i    = k;
    key_load = 1'b1;
    rd_issue = 1'b0;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  // Runs from the negedge after the load edge until busy drops; all reads
  // issued while busy must return zero. Optional injected load at cycle inj.
  task automatic run_expansion(input int inj, input logic [127:0] inj_key, output int ncyc);
    ncyc = 0;
    chk("ready_low_after_load", {127'd0, key_ready}, 128'd0);
    while (busy && ncyc < 30) begin
      if (ncyc == inj) begin
        key_i    = inj_key;
        key_load = 1'b1;
      end else begin
        key_load = 1'b0;
      end
      rk_idx_i = 4'($urandom_range(0, 15));
      rd_issue = 1'b1;
      exp_q.push_back(128'd0);
      ncyc++;
      @(negedge clk);
    end
    key_load = 1'b0;
    rd_issue = 1'b0;
    chk("busy_cycles", 128'(ncyc), 128'd10);
    chk("ready_after_expand", {127'd0, key_ready}, 128'd1);
  endtask

  task automatic read_idx(input logic [3:0] idx, input logic [127:0] exp);
    rk_idx_i = idx;
    rd_issue = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic read_model(input logic [3:0] idx);
    read_idx(idx, (idx <= 4'd10) ? mdl[idx] : 128'd0);
  endtask

  task automatic end_reads();
    rd_issue = 1'b0;
    @(negedge clk);
  endtask

  task automatic reverse_sweep();
    for (int i = 10; i >= 0; i--) read_model(4'(i));
    end_reads();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int nc;
    logic [127:0] ka, kb;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    key_i    = '0;
    key_load = 1'b0;
    rk_idx_i = '0;
    rd_issue = 1'b0;
    build_sbox();

    // Reset state
    #1;
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_ready", {127'd0, key_ready}, 128'd0);
    chk("rst_rk_o", rk_o, 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {127'd0, key_ready}, 128'd0);

    // FIPS-197 vector
    load_key(C_FIPS_KEY);
    chk("busy_after_load", {127'd0, busy}, 128'd1);
    run_expansion(-1, '0, nc);
    expand_model(C_FIPS_KEY);
    read_idx(4'd0, C_FIPS_KEY);
    read_idx(4'd1, C_FIPS_RK1);
    read_idx(4'd10, C_FIPS_RK10);
    read_idx(4'd11, 128'd0);
    read_idx(4'd15, 128'd0);
    end_reads();
    reverse_sweep();

    // Rekey from READY
    load_key(C_SEQ_KEY);
    run_expansion(-1, '0, nc);
    expand_model(C_SEQ_KEY);
    read_idx(4'd10, C_SEQ_RK10);
    end_reads();
    reverse_sweep();

    // Load during expansion is ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    load_key(ka);
    run_expansion(4, kb, nc);
    expand_model(ka);
    reverse_sweep();

    // Random keys with random reads including out-of-range indices
    for (int t = 0; t < 4; t++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      load_key(ka);
      run_expansion(-1, '0, nc);
      expand_model(ka);
      for (int r = 0; r < 12; r++) read_model(4'($urandom_range(0, 15)));
      end_reads();
    end

    // Asynchronous reset while READY with rk_o showing a key
    read_model(4'd0);
    rd_issue = 1'b0;
    #2;
    chk("rk_o_before_rst", rk_o, mdl[0]);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {127'd0, key_ready}, 128'd0);
    chk("async_rst_rk_o", rk_o, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset mid-expansion at rc_cnt = 6
    load_key(C_FIPS_KEY);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_ready", {127'd0, key_ready}, 128'd0);
    chk("mid_rst_rk_o", rk_o, 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {127'd0, busy}, 128'd0);
    chk("post_rst_ready", {127'd0, key_ready}, 128'd0);

    // Fresh load after reset must restart rcon at 01
    load_key(C_FIPS_KEY);
    run_expansion(-1, '0, nc);
    expand_model(C_FIPS_KEY);
    read_idx(4'd10, C_FIPS_RK10);
    end_reads();
    reverse_sweep();

    @(negedge clk);
    chk("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
